// File: rtl/trdb_branch_map.sv
// Branch-map accumulator for the trace encoder.
// Records the not-taken flag of each qualified retired conditional branch
// into a MAP_LEN-entry bit map (bit 0 = oldest), keeps the branch count,
// and reports full/empty/overflow status to the packet-format selector.
// The emitter clears the map with flush_i once a packet has consumed it;
// a branch arriving in the flush cycle becomes entry 0 of the new map.
module trdb_branch_map #(
  parameter int unsigned MAP_LEN = 31,
  parameter int unsigned CNT_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               branch_i,
  input  logic               taken_i,
  input  logic               flush_i,
  output logic [MAP_LEN-1:0] map_o,
  output logic [CNT_W-1:0]   branches_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic               overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAP_LEN);

  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               ovf_q, ovf_d;

  logic               rec;
  logic [MAP_LEN-1:0] base_map;
  logic [CNT_W-1:0]   base_cnt;

  assign rec = valid_i & branch_i;

  // Next-state: start from a flushed or current base, then append the branch.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    base_cnt = flush_i ? '0 : cnt_q;
    base_map = flush_i ? '0 : map_q;
    map_d    = base_map;
    cnt_d    = base_cnt;
    ovf_d    = 1'b0;
    if (rec) begin
      if (base_cnt < CNT_MAX) begin
        for (int unsigned i = 0; i < MAP_LEN; i++) begin
          if (CNT_W'(i) == base_cnt) map_d[i] = ~taken_i;
        end
        cnt_d = base_cnt + CNT_W'(1);
      end else begin
        // Full and no flush: the entry is dropped and the count saturates.
        ovf_d = 1'b1;
      end
    end
    // Status flags are decoded ahead of the register so the outputs are plain flops.
    full_d  = (cnt_d == CNT_MAX);
    empty_d = (cnt_d == '0);
  end

  // State registers with synchronous reset taking priority over flush and record.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      // NOTE: the map is reset explicitly because bits above the count must read 0.
      map_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      map_q   <= map_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  assign map_o      = map_q;
  assign branches_o = cnt_q;
  assign is_full_o  = full_q;
  assign is_empty_o = empty_q;
  assign overflow_o = ovf_q;

endmodule
